// File: rtl/inst_prefetch_q.sv
// Instruction prefetch queue: issues sequential word fetches, buffers returned
// instructions with their PC and presents them to decode. Optional zero-latency
// bypass of an empty queue is compiled in with `define PREFETCH_BYPASS_EN.
module inst_prefetch_q #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] Branch_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        deq_valid,
  output logic [31:0] deq_inst,
  output logic [31:0] deq_pc,
  input  logic        deq_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = CW + 4;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [DW-1:0] r_drop;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW-1:0] r_pf_rd;
  logic [AW-1:0] r_pf_wr;
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [31:0]   r_pf_pc  [DEPTH];

  logic [CW:0]   w_inflight;
  logic          w_grant;
  logic          w_rsp_keep;
  logic          w_rsp_drop;
  logic          w_rsp_err;
  logic          w_flush_rsp;
  logic [DW-1:0] w_drop_flush;
  logic          w_q_empty;
  logic          w_byp;
  logic          w_push;
  logic          w_pop_q;
  logic          w_unused;

  // Handshakes: a transfer happens only in a cycle where both sides are high --
  // imem_req&imem_gnt for fetches, deq_valid&deq_ready for pops (ignored on flush).
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outst};
  assign imem_req   = rst_n && !flush && (w_inflight < DEPTH_C);
  assign imem_addr  = r_fetch_pc;
  assign w_grant    = imem_req && imem_gnt;

  assign w_rsp_drop = imem_rvalid && (r_drop != '0);
  assign w_rsp_keep = imem_rvalid && (r_drop == '0) && (r_outst != '0);
  assign w_rsp_err  = imem_rvalid && (r_drop == '0) && (r_outst == '0);

  // A response landing in the flush cycle belongs to the old stream and is discarded.
  assign w_flush_rsp  = imem_rvalid && ((r_drop != '0) || (r_outst != '0));
  assign w_drop_flush = r_drop + DW'(r_outst) - DW'(w_flush_rsp);

  assign w_q_empty = (r_count == '0);

`ifdef PREFETCH_BYPASS_EN
  assign w_byp = w_q_empty && w_rsp_keep && !flush;
`else
  assign w_byp = 1'b0;
`endif

  assign w_push   = w_rsp_keep && !flush && !(w_byp && deq_ready);
  assign w_pop_q  = !w_q_empty && deq_ready && !flush;
  assign w_unused = ^Branch_PC[1:0];

  always_comb begin
    deq_valid = 1'b0;
    deq_inst  = 32'h0;
    deq_pc    = 32'h0;
    if (!w_q_empty) begin
      deq_valid = 1'b1;
      deq_inst  = r_q_inst[r_head];
      deq_pc    = r_q_pc[r_head];
    end else if (w_byp) begin
      deq_valid = 1'b1;
      deq_inst  = imem_rdata;
      deq_pc    = r_pf_pc[r_pf_rd];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_pf_rd    <= '0;
      r_pf_wr    <= '0;
    end else if (flush) begin
      r_fetch_pc <= {Branch_PC[31:2], 2'b00};
      r_count    <= '0;
      r_outst    <= '0;
      r_drop     <= w_drop_flush;
      r_head     <= '0;
      r_tail     <= '0;
      r_pf_rd    <= '0;
      r_pf_wr    <= '0;
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_pf_wr    <= r_pf_wr + AW'(1);
      end
      if (w_rsp_keep) r_pf_rd <= r_pf_rd + AW'(1);
      if (w_rsp_drop) r_drop <= r_drop - DW'(1);
      if (w_push)     r_tail <= r_tail + AW'(1);
      if (w_pop_q)    r_head <= r_head + AW'(1);
      r_outst <= r_outst + CW'(w_grant) - CW'(w_rsp_keep);
      r_count <= r_count + CW'(w_push) - CW'(w_pop_q);
    end
  end

  // Storage needs no reset: entries are only visible once counted as valid.
  always_ff @(posedge clk) begin
    if (w_grant) r_pf_pc[r_pf_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_inst[r_tail] <= imem_rdata;
      r_q_pc[r_tail]   <= r_pf_pc[r_pf_rd];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) assert (!w_rsp_err) else $error("stray imem_rvalid with nothing outstanding");
  end
`endif

endmodule

// File: tb/tb_inst_prefetch_q.sv
// Directed bench for inst_prefetch_q; expectations adapt to PREFETCH_BYPASS_EN.
module tb_inst_prefetch_q;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] Branch_PC = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic        deq_ready = 1'b0;

  inst_prefetch_q #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .Branch_PC(Branch_PC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_ready(deq_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int gnt_cnt = 0;
  int pop_cnt = 0;
  int first_pop = 0;
  int last_pop = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];

  logic        g_gnt, g_ready, g_flush, g_rsp;
  logic [31:0] g_bpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, settle, log handshakes and score pops.
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    imem_gnt  = g_gnt;
    deq_ready = g_ready;
    flush     = g_flush;
    Branch_PC = g_bpc;
    if (g_rsp && pend_q.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~pend_q[0];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    cyc_n++;
    if (imem_rvalid) void'(pend_q.pop_front());
    if (imem_req && imem_gnt) begin
      pend_q.push_back(imem_addr);
      gnt_cnt++;
    end
    if (deq_valid && deq_ready && !flush) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexp_pop observed=%h expected=none", deq_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", deq_pc, e);
        chk("pop_inst", deq_inst, ~e);
      end
      if (pop_cnt == 0) first_pop = cyc_n;
      last_pop = cyc_n;
      pop_cnt++;
    end
  endtask

  task automatic drain(input string tag, input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      cyc();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    flush = 1'b0; Branch_PC = 32'h0; deq_ready = 1'b0;
    g_gnt = 1'b0; g_ready = 1'b0; g_flush = 1'b0; g_rsp = 1'b0; g_bpc = 32'h0;
    pend_q.delete();
    exp_q.delete();
    gnt_cnt = 0; pop_cnt = 0;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(deq_valid), 32'h0);
    chk("rst_inst", deq_inst, 32'h0);
    chk("rst_pc", deq_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: streaming, one instruction per cycle
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    g_gnt = 1'b1; g_rsp = 1'b1; g_ready = 1'b1;
    cyc();
    chk("p1_req0", 32'(imem_req), 32'h1);
    chk("p1_addr0", imem_addr, 32'h0);
    cyc();
    chk("p1_addr1", imem_addr, 32'h4);
    chk("p1_lat_v1", 32'(deq_valid), 32'(BYP));
    cyc();
    chk("p1_addr2", imem_addr, 32'h8);
    chk("p1_lat_v2", 32'(deq_valid), 32'h1);
    drain("p1_drain", 40);
    chk("p1_rate", 32'(last_pop - first_pop), 32'd9);
    g_ready = 1'b0;

    // 2: decode stalled -> exactly DEPTH grants, then drain in order (reset mid-stream)
    do_reset();
    g_gnt = 1'b1; g_rsp = 1'b1; g_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("p2_grants", 32'(gnt_cnt), 32'd4);
    chk("p2_req_off", 32'(imem_req), 32'h0);
    chk("p2_head_v", 32'(deq_valid), 32'h1);
    chk("p2_head_pc", deq_pc, 32'h0);
    chk("p2_head_inst", deq_inst, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    g_ready = 1'b1;
    cyc();
    chk("p2_req_full", 32'(imem_req), 32'h0);
    cyc();
    chk("p2_req_resume", 32'(imem_req), 32'h1);
    chk("p2_addr_resume", imem_addr, 32'h10);
    drain("p2_drain", 30);
    g_ready = 1'b0;

    // 3: three outstanding, flush to 0x100 -> old responses dropped
    do_reset();
    g_gnt = 1'b1; g_rsp = 1'b0; g_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("p3_outst", 32'(gnt_cnt), 32'd3);
    g_flush = 1'b1; g_bpc = 32'h100;
    cyc();
    chk("p3_req_flush", 32'(imem_req), 32'h0);
    g_flush = 1'b0; g_rsp = 1'b1; g_ready = 1'b1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    cyc();
    chk("p3_req_after", 32'(imem_req), 32'h1);
    chk("p3_addr_after", imem_addr, 32'h100);
    chk("p3_valid_after", 32'(deq_valid), 32'h0);
    drain("p3_drain", 40);
    g_ready = 1'b0;

    // 4: flush with pop and rvalid in the same cycle; Branch_PC low bits ignored
    do_reset();
    g_gnt = 1'b1; g_rsp = 1'b1; g_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("p4_pre_v", 32'(deq_valid), 32'h1);
    chk("p4_pre_pc", deq_pc, 32'h0);
    g_flush = 1'b1; g_bpc = 32'h203; g_ready = 1'b1;
    cyc();
    chk("p4_rvalid_in_flush", 32'(imem_rvalid), 32'h1);
    chk("p4_req_flush", 32'(imem_req), 32'h0);
    g_flush = 1'b0;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    cyc();
    chk("p4_valid_after", 32'(deq_valid), 32'h0);
    chk("p4_addr_after", imem_addr, 32'h200);
    drain("p4_drain", 40);
    g_ready = 1'b0;

    // 5: fetch address wraps at the top of the address space
    do_reset();
    g_flush = 1'b1; g_bpc = 32'hFFFF_FFF8;
    cyc();
    g_flush = 1'b0; g_gnt = 1'b1; g_rsp = 1'b1; g_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    cyc();
    chk("p5_addr0", imem_addr, 32'hFFFF_FFF8);
    cyc();
    chk("p5_addr1", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("p5_addr2", imem_addr, 32'h0);
    drain("p5_drain", 30);
    g_ready = 1'b0;

    // 6: single response into an empty queue (bypass timing when compiled in)
    do_reset();
    g_gnt = 1'b1; g_rsp = 1'b1; g_ready = 1'b1;
    exp_q.push_back(32'h0);
    cyc();
    g_gnt = 1'b0;
    cyc();
    chk("p6_v_rsp", 32'(deq_valid), 32'(BYP));
    chk("p6_inst_rsp", deq_inst, BYP ? 32'hFFFF_FFFF : 32'h0);
    cyc();
    chk("p6_v_next", 32'(deq_valid), 32'(!BYP));
    cyc();
    chk("p6_v_idle", 32'(deq_valid), 32'h0);
    chk("p6_done", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
